// File: rtl/ram_initiator_pkg.sv
// Shared constants for the RAM-cell access controller: state encoding, default widths,
// and write-strobe polarity.
package ram_initiator_pkg;

  localparam int unsigned ADDR_W_DEF = 2;
  localparam int unsigned DATA_W_DEF = 4;

  localparam logic R_W_WRITE = 1'b1;
  localparam logic R_W_READ  = 1'b0;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_SAMPLE = 3'd4;
  localparam logic [2:0] ST_VERIFY = 3'd5;
  localparam logic [2:0] ST_RESP   = 3'd6;

  // States in which the addressed word must stay selected.
  function automatic logic sel_active(input logic [2:0] st);
    return (st == ST_SETUP) || (st == ST_STROBE) || (st == ST_HOLD) ||
           (st == ST_SAMPLE) || (st == ST_VERIFY);
  endfunction

endpackage

// File: rtl/ram_initiator_addr_onehot_decoder.sv
// Binary address to one-hot word select; all-zero output while disabled.
module addr_onehot_decoder #(
  parameter int unsigned ADDR_W = 2
) (
  input  logic                 i_en,
  input  logic [ADDR_W-1:0]    i_addr,
  output logic [2**ADDR_W-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_addr] = 1'b1;
    end
  end

endmodule

// File: rtl/ram_initiator.sv
// Request-driven setup/strobe/hold access sequencer for the 1-bit RAM cell bank.
// Define RAM_WRITE_VERIFY_EN to add a read-back VERIFY step after every write.
module ram_initiator
  import ram_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 resp_valid,
  output logic [DATA_W-1:0]    resp_rdata,
  output logic                 resp_err,
  output logic [2**ADDR_W-1:0] ram_sel,
  output logic                 ram_r_w,
  output logic [DATA_W-1:0]    ram_wdata,
  input  logic [DATA_W-1:0]    ram_rdata
);

  logic [2:0]           r_state;
  logic [2:0]           w_state_d;
  logic                 r_we;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic [2**ADDR_W-1:0] r_sel;
  logic [2**ADDR_W-1:0] w_sel;
  logic                 r_rw;
  logic                 w_rw;
  logic [DATA_W-1:0]    r_rdata;
  logic                 w_accept;
  logic [ADDR_W-1:0]    w_dec_addr;

  assign req_ready = (r_state == ST_IDLE) && !clear;
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_accept) w_state_d = ST_SETUP;
      ST_SETUP:  w_state_d = r_we ? ST_STROBE : ST_SAMPLE;
      ST_STROBE: w_state_d = ST_HOLD;
`ifdef RAM_WRITE_VERIFY_EN
      ST_HOLD:   w_state_d = ST_VERIFY;
      ST_VERIFY: w_state_d = ST_RESP;
`else
      ST_HOLD:   w_state_d = ST_RESP;
`endif
      ST_SAMPLE: w_state_d = ST_RESP;
      ST_RESP:   w_state_d = ST_IDLE;
      default:   w_state_d = ST_IDLE;
    endcase
  end

  // Array drive is computed from the next state so it is registered and glitch-free.
  assign w_dec_addr = w_accept ? req_addr : r_addr;
  assign w_rw       = (w_state_d == ST_STROBE) ? R_W_WRITE : R_W_READ;

  addr_onehot_decoder #(
    .ADDR_W (ADDR_W)
  ) u_dec (
    .i_en     (sel_active(w_state_d)),
    .i_addr   (w_dec_addr),
    .o_onehot (w_sel)
  );

`ifdef RAM_WRITE_VERIFY_EN
  logic r_err;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_err <= 1'b0;
    end else if (r_state == ST_VERIFY) begin
      r_err <= (ram_rdata != r_wdata);
    end else if (r_state == ST_RESP) begin
      r_err <= 1'b0;
    end
  end

  assign resp_err = r_err;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
      r_rw    <= R_W_READ;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_d;
      r_sel   <= w_sel;
      r_rw    <= w_rw;
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state == ST_SAMPLE) begin
        r_rdata <= ram_rdata;
      end
`ifdef RAM_WRITE_VERIFY_EN
      if (r_state == ST_VERIFY) begin
        r_rdata <= ram_rdata;
      end
`else
      if (r_state == ST_HOLD) begin
        r_rdata <= '0;
      end
`endif
    end
  end

  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_rdata;
  assign ram_sel    = r_sel;
  assign ram_r_w    = r_rw;
  assign ram_wdata  = r_wdata;

endmodule

// File: tb/tb_ram_initiator.sv
// Scoreboard bench for ram_initiator with a behavioural 4x4 cell array model.
module tb_ram_initiator;

`ifdef RAM_WRITE_VERIFY_EN
  localparam bit Verify = 1'b1;
`else
  localparam bit Verify = 1'b0;
`endif
  localparam int WLat = Verify ? 4 : 3;
  localparam int RLat = 2;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [1:0] req_addr = '0;
  logic [3:0] req_wdata = '0;
  logic       resp_valid;
  logic [3:0] resp_rdata;
  logic       resp_err;
  logic [3:0] ram_sel;
  logic       ram_r_w;
  logic [3:0] ram_wdata;
  logic [3:0] ram_rdata;

  ram_initiator #(
    .ADDR_W (2),
    .DATA_W (4)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .ram_sel    (ram_sel),
    .ram_r_w    (ram_r_w),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Cell array model: clock-gated write of selected words, OR-combined read.
  logic [3:0] mem [4];
  logic       stuck0 = 1'b0;
  initial for (int i = 0; i < 4; i++) mem[i] = 4'b0000;

  always @(posedge clk) begin
    if (ram_r_w) begin
      for (int i = 0; i < 4; i++) if (ram_sel[i]) mem[i] <= ram_wdata;
    end
  end

  always_comb begin
    ram_rdata = 4'b0000;
    for (int i = 0; i < 4; i++) if (ram_sel[i]) ram_rdata = ram_rdata | mem[i];
    if (stuck0) ram_rdata[0] = 1'b0;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] rd;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    if (!clear && resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", {28'd0, resp_rdata}, {28'd0, e.rd});
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  // Waits (bounded) for ready, issues one request and pushes its expected response.
  task automatic issue(input logic we, input logic [1:0] addr, input logic [3:0] wd,
                       input logic [3:0] exp_rd, input logic exp_err, input bit keep,
                       output int waits);
    waits = 0;
    @(negedge clk);
    while (!req_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    sb.push_back('{rd: exp_rd, err: exp_err, cyc: cyc + (we ? WLat : RLat)});
    if (!keep) req_valid = 1'b0;
  endtask

  initial begin
    int w;
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // Reset state while clear is high
    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_sel", {28'd0, ram_sel}, 32'd0);
    chk("rst_r_w", {31'd0, ram_r_w}, 32'd0);
    chk("rst_wdata", {28'd0, ram_wdata}, 32'd0);
    chk("rst_rdata", {28'd0, resp_rdata}, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("rst_ready_after", {31'd0, req_ready}, 32'd1);

    // Write addr 2 = 1011 with cycle-by-cycle array drive checks
    issue(1'b1, 2'd2, 4'b1011, 4'b0000, 1'b0, 1'b0, w);
    chk("w_sel_e0", {28'd0, ram_sel}, 32'b0100);
    chk("w_rw_e0", {31'd0, ram_r_w}, 32'd0);
    chk("w_wdata_e0", {28'd0, ram_wdata}, 32'b1011);
    @(negedge clk);
    @(negedge clk);
    chk("w_rw_e1", {31'd0, ram_r_w}, 32'd1);
    chk("w_sel_e1", {28'd0, ram_sel}, 32'b0100);
    @(negedge clk);
    chk("w_rw_e2", {31'd0, ram_r_w}, 32'd0);
    chk("w_sel_e2", {28'd0, ram_sel}, 32'b0100);
    @(negedge clk);
    chk("w_sel_e3", {28'd0, ram_sel}, Verify ? 32'b0100 : 32'b0000);
    chk("w_ready_e3", {31'd0, req_ready}, 32'd0);

    // Read it back
    issue(1'b0, 2'd2, 4'b0000, 4'b1011, 1'b0, 1'b0, w);
    chk("r_sel_e0", {28'd0, ram_sel}, 32'b0100);
    chk("r_rw_e0", {31'd0, ram_r_w}, 32'd0);

    // valid held high across a write: second request waits for ready
    issue(1'b1, 2'd3, 4'b0101, 4'b0000, 1'b0, 1'b1, w);
    issue(1'b1, 2'd3, 4'b0101, 4'b0000, 1'b0, 1'b0, w);
    chk("b2b_wait", w, WLat + 1);
    issue(1'b0, 2'd3, 4'b0000, 4'b0101, 1'b0, 1'b0, w);

    // clear pulsed during STROBE aborts the write without a response
    issue(1'b1, 2'd1, 4'b0110, 4'b0000, 1'b0, 1'b0, w);
    void'(sb.pop_back());
    @(negedge clk);
    @(negedge clk);
    chk("clr_rw_before", {31'd0, ram_r_w}, 32'd1);
    clear = 1'b1;
    #1;
    chk("clr_rw", {31'd0, ram_r_w}, 32'd0);
    chk("clr_sel", {28'd0, ram_sel}, 32'd0);
    chk("clr_ready", {31'd0, req_ready}, 32'd0);
    repeat (3) @(negedge clk);
    chk("clr_no_resp", {31'd0, resp_valid}, 32'd0);
    clear = 1'b0;
    #1;
    chk("clr_ready_after", {31'd0, req_ready}, 32'd1);
    issue(1'b0, 2'd1, 4'b0000, 4'b0000, 1'b0, 1'b0, w);

`ifdef RAM_WRITE_VERIFY_EN
    // bit0 stuck-at-0: verify must flag the mismatch
    issue(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, w);
    stuck0 = 1'b1;
    issue(1'b1, 2'd0, 4'b0001, 4'b0000, 1'b1, 1'b0, w);
    repeat (6) @(negedge clk);
    stuck0 = 1'b0;
`endif

    // All words = 1111, then read each; select must be strictly one-hot
    for (int a = 0; a < 4; a++) begin
      issue(1'b1, a[1:0], 4'b1111, 4'b0000, 1'b0, 1'b0, w);
      chk("all_w_sel", {28'd0, ram_sel}, 32'd1 << a);
    end
    for (int a = 0; a < 4; a++) begin
      issue(1'b0, a[1:0], 4'b0000, 4'b1111, 1'b0, 1'b0, w);
      chk("all_r_sel", {28'd0, ram_sel}, 32'd1 << a);
    end

    repeat (8) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
